// File: rtl/pb_sram_writer_pkg.sv
// +--------------------------------------------------------------------------+
// | pb_sram_writer_pkg                                                        |
// | Shared pixel-buffer entry layout, frame size and writer state encoding.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package pb_sram_writer_pkg;

    localparam int NUM_RAYS   = 307200;
    localparam int PIXEL_ID_W = 19;
    localparam int COLOR_W    = 24;

    typedef struct packed {
        logic [COLOR_W-1:0]    color;
        logic [PIXEL_ID_W-1:0] pixel_id;
    } pixel_buffer_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } pbw_state_t;

endpackage

`default_nettype wire

// File: rtl/pb_sram_writer.sv
// +--------------------------------------------------------------------------+
// | pb_sram_writer                                                            |
// | Drains pixel-buffer entries into the 16-bit SRAM frame store as two       |
// | halfword writes per pixel and counts committed pixels per frame.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pb_sram_writer
    import pb_sram_writer_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_RAYS
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 pb_empty,
    input  pixel_buffer_entry_t  pb_data,
    output logic                 pb_re,
    output logic                 sram_req,
    input  logic                 sram_grant,
    output logic [19:0]          sram_addr,
    output logic [15:0]          sram_wdata,
    output logic                 sram_we_b,
    output logic                 sram_ub_b,
    output logic                 sram_lb_b,
    output logic [18:0]          pixels_written,
    output logic                 frame_done,
    output logic                 bad_id
);

    localparam logic [19:0] c_num_pixels = 20'(NUM_PIXELS);
    localparam logic [18:0] c_last_pixel = 19'(NUM_PIXELS - 1);

    pbw_state_t  r_state_q, w_state_d;
    logic [18:0] r_hold_id_q, w_hold_id_d;
    logic [7:0]  r_hold_red_q, w_hold_red_d;
    logic [19:0] r_addr_q, w_addr_d;
    logic [15:0] r_wdata_q, w_wdata_d;
    logic        r_ub_b_q, w_ub_b_d;
    logic        r_lb_b_q, w_lb_b_d;
    logic        r_req_q, w_req_d;
    logic [18:0] r_count_q, w_count_d;
    logic        r_done_q, w_done_d;
    logic        r_bad_q, w_bad_d;
    logic        w_pop;
    logic        w_id_ok;

    always_comb begin
        w_state_d    = r_state_q;
        w_hold_id_d  = r_hold_id_q;
        w_hold_red_d = r_hold_red_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_ub_b_d     = r_ub_b_q;
        w_lb_b_d     = r_lb_b_q;
        w_req_d      = r_req_q;
        w_count_d    = r_count_q;
        w_done_d     = 1'b0;
        w_bad_d      = r_bad_q;
        w_pop        = 1'b0;
        w_id_ok      = ({1'b0, pb_data.pixel_id} < c_num_pixels);

        case (r_state_q)
            IDLE: begin
                w_pop = !pb_empty;
            end
            WR_LO: begin
                if (sram_grant) begin
                    w_state_d = WR_HI;
                    w_addr_d  = {r_hold_id_q, 1'b1};
                    w_wdata_d = {8'h00, r_hold_red_q};
                    w_ub_b_d  = 1'b1;
                    w_lb_b_d  = 1'b0;
                end
            end
            WR_HI: begin
                if (sram_grant) begin
                    if (r_count_q == c_last_pixel) begin
                        w_count_d = '0;
                        w_done_d  = 1'b1;
                    end else begin
                        w_count_d = r_count_q + 19'd1;
                    end
                    w_pop     = !pb_empty;
                    w_state_d = IDLE;
                    w_req_d   = 1'b0;
                    w_ub_b_d  = 1'b1;
                    w_lb_b_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_req_d   = 1'b0;
            end
        endcase

        // A popped entry overrides the IDLE fallback chosen above, which is
        // what makes the granted WR_HI -> WR_LO hand-off bubble-free.
        if (w_pop) begin
            w_hold_id_d  = pb_data.pixel_id;
            w_hold_red_d = pb_data.color[23:16];
            if (w_id_ok) begin
                w_state_d = WR_LO;
                w_req_d   = 1'b1;
                w_addr_d  = {pb_data.pixel_id, 1'b0};
                w_wdata_d = pb_data.color[15:0];
                w_ub_b_d  = 1'b0;
                w_lb_b_d  = 1'b0;
            end else begin
                w_bad_d   = 1'b1;
                w_state_d = IDLE;
                w_req_d   = 1'b0;
                w_ub_b_d  = 1'b1;
                w_lb_b_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state_q    <= IDLE;
            r_hold_id_q  <= '0;
            r_hold_red_q <= '0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_ub_b_q     <= 1'b1;
            r_lb_b_q     <= 1'b1;
            r_req_q      <= 1'b0;
            r_count_q    <= '0;
            r_done_q     <= 1'b0;
            r_bad_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_hold_id_q  <= w_hold_id_d;
            r_hold_red_q <= w_hold_red_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_ub_b_q     <= w_ub_b_d;
            r_lb_b_q     <= w_lb_b_d;
            r_req_q      <= w_req_d;
            r_count_q    <= w_count_d;
            r_done_q     <= w_done_d;
            r_bad_q      <= w_bad_d;
        end
    end

    // Write strobe follows the grant combinationally so reset drops it at once.
    assign sram_we_b      = ~(((r_state_q == WR_LO) || (r_state_q == WR_HI)) && sram_grant);
    assign pb_re          = w_pop;
    assign sram_req       = r_req_q;
    assign sram_addr      = r_addr_q;
    assign sram_wdata     = r_wdata_q;
    assign sram_ub_b      = r_ub_b_q;
    assign sram_lb_b      = r_lb_b_q;
    assign pixels_written = r_count_q;
    assign frame_done     = r_done_q;
    assign bad_id         = r_bad_q;

endmodule

`default_nettype wire
